stack_control_unit: RTL and testbench

- Multicycle control FSM directly upstream of the LinkedDatapath.
- Consumes opcode/isZero/ovfl from the datapath and drives every datapath control input each CLK cycle.
- Sequences FETCH → DECODE → per-opcode execute states; provides run/halt gating, trap detection and a retired-instruction counter for bring-up.

---
 rtl/stack_ctrl_pkg.sv | 67 ++++++
 rtl/stack_ctrl_decode.sv | 77 +++++++
 rtl/stack_control_unit.sv | 105 ++++++++++
 tb/tb_stack_control_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared states, opcodes, mux encodings and control vector for the stack control unit
package stack_ctrl_pkg;

    typedef enum logic [3:0] {
        INIT, FETCH, DECODE, ODPP, PUSH, ALU, DROP, BRZ, JMP, CALL, RET, HALT, TRAP
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_DROP = 4'h6;
    localparam logic [3:0] OP_BRZ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_CALL = 4'h9;
    localparam logic [3:0] OP_RET  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RSTACK = 2'b10;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;

    localparam logic [1:0] MA_PC     = 2'b00;
    localparam logic [1:0] MA_RSTACK = 2'b01;

    localparam logic [2:0] TR_ALU  = 3'b001;
    localparam logic [2:0] TR_PUSH = 3'b011;
    localparam logic [2:0] B_TOP   = 3'b000;

    typedef struct packed {
        logic [1:0] pc_src;
        logic [1:0] rp_inc;
        logic       pc_enable;
        logic [1:0] mem_addr;
        logic       mem_data;
        logic       mem_write;
        logic       ir_write;
        logic [2:0] tr_src;
        logic [1:0] dp_inc;
        logic       reg_write;
        logic       tr_write;
        logic [2:0] b_src;
        logic       b_write;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       halted;
        logic       trap;
    } ctrl_t;

    function automatic logic [3:0] alu_op_of(input logic [3:0] op);
        return op == OP_ADD ? ALU_ADD : op == OP_SUB ? ALU_SUB :
               op == OP_AND ? ALU_AND : op == OP_OR ? ALU_OR : ALU_NONE;
    endfunction

endpackage

// File: rtl/stack_ctrl_decode.sv
// stack_ctrl_decode: maps FSM state, latched opcode and flags onto the datapath control vector
module stack_ctrl_decode
    import stack_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  state_t              state,
    input  logic                run,
    input  logic [OPCODE_W-1:0] op,
    input  logic                is_zero,
    output ctrl_t               ctrl
);

    // per-state control vector on top of the default (only b_write set)
    always_comb begin
        ctrl = '0;
        ctrl.b_write = 1'b1;
        case (state)
            INIT: ctrl = '0;
            FETCH: begin
                ctrl.mem_addr  = MA_PC;
                ctrl.pc_src    = PC_NEXT;
                ctrl.ir_write  = run;
                ctrl.pc_enable = run;
            end
            DECODE: ctrl.b_src = B_TOP;
            ODPP: begin
                ctrl.dp_inc  = SP_INC;
                ctrl.b_write = 1'b0;
            end
            PUSH: begin
                ctrl.reg_write = 1'b1;
                ctrl.tr_src    = TR_PUSH;
                ctrl.tr_write  = 1'b1;
            end
            ALU: begin
                ctrl.dp_inc   = SP_DEC;
                ctrl.tr_src   = TR_ALU;
                ctrl.tr_write = 1'b1;
                ctrl.alu_src  = 1'b1;
                ctrl.alu_op   = alu_op_of(op);
            end
            DROP: ctrl.dp_inc = SP_DEC;
            BRZ: begin
                ctrl.pc_src    = PC_BRANCH;
                ctrl.pc_enable = is_zero;
                ctrl.dp_inc    = SP_DEC;
            end
            JMP: begin
                ctrl.pc_src    = PC_BRANCH;
                ctrl.pc_enable = 1'b1;
            end
            CALL: begin
                ctrl.rp_inc    = SP_INC;
                ctrl.mem_addr  = MA_RSTACK;
                ctrl.mem_data  = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            RET: begin
                ctrl.rp_inc    = SP_DEC;
                ctrl.pc_src    = PC_RSTACK;
                ctrl.pc_enable = 1'b1;
            end
            HALT: begin
                ctrl = '0;
                ctrl.halted = 1'b1;
            end
            TRAP: begin
                ctrl = '0;
                ctrl.halted = 1'b1;
                ctrl.trap   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/stack_control_unit.sv
// stack_control_unit: multicycle FSM sequencing the stack datapath, with run gating, traps and a retired count
module stack_control_unit
    import stack_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ICOUNT_W = 16
) (
    input  logic                CLK,
    input  logic                reset_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                isZero,
    input  logic                ovfl,
    output logic [1:0]          pc_src,
    output logic [1:0]          rp_inc,
    output logic                pc_enable,
    output logic [1:0]          mem_addr,
    output logic                mem_data,
    output logic                mem_write,
    output logic                ir_write,
    output logic [2:0]          tr_src,
    output logic [1:0]          dp_inc,
    output logic                reg_write,
    output logic                tr_write,
    output logic [2:0]          b_src,
    output logic                b_write,
    output logic                alu_src,
    output logic [3:0]          alu_op,
    output logic                halted,
    output logic                trap,
    output logic [ICOUNT_W-1:0] icount
);

    state_t              state, nxt;
    logic [OPCODE_W-1:0] op_q;
    ctrl_t               ctrl;

    // next state; DECODE dispatches on the live opcode, HALT and TRAP hold until reset
    always_comb begin
        nxt = state;
        case (state)
            INIT:   nxt = FETCH;
            FETCH:  nxt = run ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_NOP:                          nxt = FETCH;
                    OP_PUSH:                         nxt = ODPP;
                    OP_ADD, OP_SUB, OP_AND, OP_OR:   nxt = ALU;
                    OP_DROP:                         nxt = DROP;
                    OP_BRZ:                          nxt = BRZ;
                    OP_JMP:                          nxt = JMP;
                    OP_CALL:                         nxt = CALL;
                    OP_RET:                          nxt = RET;
                    OP_HALT:                         nxt = HALT;
                    default:                         nxt = TRAP;
                endcase
            end
            ODPP:                 nxt = PUSH;
            ALU:                  nxt = ovfl ? TRAP : FETCH;
            CALL:                 nxt = JMP;
            PUSH, DROP, BRZ, JMP, RET: nxt = FETCH;
            default:              nxt = state;
        endcase
    end

    // state, opcode latch and retired count; an instruction retires on its return to FETCH
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state  <= INIT;
            op_q   <= '0;
            icount <= '0;
        end else begin
            state <= nxt;
            if (state == DECODE) op_q <= opcode;
            if (nxt == FETCH && state != INIT && state != FETCH) icount <= icount + 1'b1;
        end
    end

    stack_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .state   (state),
        .run     (run),
        .op      (op_q),
        .is_zero (isZero),
        .ctrl    (ctrl)
    );

    assign pc_src    = ctrl.pc_src;
    assign rp_inc    = ctrl.rp_inc;
    assign pc_enable = ctrl.pc_enable;
    assign mem_addr  = ctrl.mem_addr;
    assign mem_data  = ctrl.mem_data;
    assign mem_write = ctrl.mem_write;
    assign ir_write  = ctrl.ir_write;
    assign tr_src    = ctrl.tr_src;
    assign dp_inc    = ctrl.dp_inc;
    assign reg_write = ctrl.reg_write;
    assign tr_write  = ctrl.tr_write;
    assign b_src     = ctrl.b_src;
    assign b_write   = ctrl.b_write;
    assign alu_src   = ctrl.alu_src;
    assign alu_op    = ctrl.alu_op;
    assign halted    = ctrl.halted;
    assign trap      = ctrl.trap;

endmodule

// File: tb/tb_stack_control_unit.sv
// tb_stack_control_unit: instruction-level model of the control unit checked cycle by cycle
module tb_stack_control_unit;

    typedef struct packed {
        logic [1:0] pc_src;
        logic [1:0] rp_inc;
        logic       pc_enable;
        logic [1:0] mem_addr;
        logic       mem_data;
        logic       mem_write;
        logic       ir_write;
        logic [2:0] tr_src;
        logic [1:0] dp_inc;
        logic       reg_write;
        logic       tr_write;
        logic [2:0] b_src;
        logic       b_write;
        logic       alu_src;
        logic [3:0] alu_op;
        logic       halted;
        logic       trap;
    } ctl_t;

    typedef struct {
        logic [3:0] op;
        logic       z;
        logic       v;
        logic       hlt;
        logic       trp;
        int         inc;
    } vec_t;

    logic        CLK, reset_n, run, isZero, ovfl;
    logic [3:0]  opcode;
    logic [1:0]  pc_src, rp_inc, mem_addr, dp_inc;
    logic        pc_enable, mem_data, mem_write, ir_write, reg_write, tr_write;
    logic        b_write, alu_src, halted, trap;
    logic [2:0]  tr_src, b_src;
    logic [3:0]  alu_op;
    logic [15:0] icount;
    ctl_t        act;

    int    n_pass, n_tot, m_ic;
    string plan[$];
    bit    plan_term;
    vec_t  tbl[16];

    stack_control_unit dut (
        .CLK(CLK), .reset_n(reset_n), .run(run), .opcode(opcode), .isZero(isZero), .ovfl(ovfl),
        .pc_src(pc_src), .rp_inc(rp_inc), .pc_enable(pc_enable), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_write(mem_write), .ir_write(ir_write), .tr_src(tr_src),
        .dp_inc(dp_inc), .reg_write(reg_write), .tr_write(tr_write), .b_src(b_src),
        .b_write(b_write), .alu_src(alu_src), .alu_op(alu_op), .halted(halted), .trap(trap),
        .icount(icount)
    );

    assign act = {pc_src, rp_inc, pc_enable, mem_addr, mem_data, mem_write, ir_write, tr_src,
                  dp_inc, reg_write, tr_write, b_src, b_write, alu_src, alu_op, halted, trap};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic ctl_t ev(input string ph, input logic [3:0] op, input logic z);
        ctl_t e;
        e = '0;
        e.b_write = 1'b1;
        case (ph)
            "FETCH": begin e.ir_write = 1; e.pc_enable = 1; end
            "ODPP":  begin e.dp_inc = 2'b01; e.b_write = 0; end
            "PUSH":  begin e.reg_write = 1; e.tr_src = 3'b011; e.tr_write = 1; end
            "ALU": begin
                e.dp_inc = 2'b10; e.tr_src = 3'b001; e.tr_write = 1; e.alu_src = 1;
                e.alu_op = (op >= 4'h2 && op <= 4'h5) ? op - 4'h1 : 4'h0;
            end
            "DROP":  e.dp_inc = 2'b10;
            "BRZ":   begin e.pc_src = 2'b01; e.pc_enable = z; e.dp_inc = 2'b10; end
            "JMP":   begin e.pc_src = 2'b01; e.pc_enable = 1; end
            "CALL":  begin e.rp_inc = 2'b01; e.mem_addr = 2'b01; e.mem_data = 1; e.mem_write = 1; end
            "RET":   begin e.rp_inc = 2'b10; e.pc_src = 2'b10; e.pc_enable = 1; end
            "INIT":  e = '0;
            "HALT":  begin e = '0; e.halted = 1; end
            "TRAP":  begin e = '0; e.halted = 1; e.trap = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input ctl_t e, input string nm);
        #1;
        n_tot++;
        if (act === e && icount === 16'(m_ic)) n_pass++;
        else $display("FAIL %s: got ctl=%h icount=%0d, want ctl=%h icount=%0d", nm, act, icount, e, 16'(m_ic));
        @(negedge CLK);
    endtask

    task automatic build_plan(input logic [3:0] op, input logic v, input int stalls);
        plan.delete();
        repeat (stalls) plan.push_back("STALL");
        plan.push_back("FETCH");
        plan.push_back("DECODE");
        case (op)
            4'h0: ;
            4'h1: begin plan.push_back("ODPP"); plan.push_back("PUSH"); end
            4'h2, 4'h3, 4'h4, 4'h5: begin
                plan.push_back("ALU");
                if (v) repeat (3) plan.push_back("TRAP");
            end
            4'h6: plan.push_back("DROP");
            4'h7: plan.push_back("BRZ");
            4'h8: plan.push_back("JMP");
            4'h9: begin plan.push_back("CALL"); plan.push_back("JMP"); end
            4'hA: plan.push_back("RET");
            4'hF: repeat (3) plan.push_back("HALT");
            default: repeat (3) plan.push_back("TRAP");
        endcase
        plan_term = plan[$] == "TRAP" || plan[$] == "HALT";
    endtask

    task automatic run_plan(input logic [3:0] op, input logic z, input logic v);
        foreach (plan[i]) begin
            string ph;
            ph = plan[i];
            run    = ph == "STALL" ? 1'b0 : ph == "FETCH" ? 1'b1 : 1'($urandom);
            opcode = ph == "DECODE" ? op : 4'($urandom);
            isZero = ph == "BRZ" ? z : 1'($urandom);
            ovfl   = ph == "ALU" ? v : 1'($urandom);
            chk(ev(ph, op, z), $sformatf("%s op=%h", ph, op));
        end
        if (!plan_term) m_ic++;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b1;
        m_ic = 0;
        chk(ev("INIT", 4'h0, 1'b0), "reset_a");
        chk(ev("INIT", 4'h0, 1'b0), "reset_b");
        reset_n = 1'b1;
        chk(ev("INIT", 4'h0, 1'b0), "reset_release");
    endtask

    initial begin
        logic [3:0] rop;
        logic       rz, rv;
        int         ic0;
        reset_n = 0; run = 0; opcode = 0; isZero = 0; ovfl = 0;
        n_pass = 0; n_tot = 0; m_ic = 0;
        tbl[0]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[1]  = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[2]  = '{4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[3]  = '{4'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[4]  = '{4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[5]  = '{4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[6]  = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[7]  = '{4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{4'h8, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[9]  = '{4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[10] = '{4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[11] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[12] = '{4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 0};
        tbl[13] = '{4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        tbl[14] = '{4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        tbl[15] = '{4'hE, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        @(negedge CLK);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ic0 = m_ic;
            build_plan(tbl[i].op, tbl[i].v, 0);
            run_plan(tbl[i].op, tbl[i].z, tbl[i].v);
            #1;
            n_tot++;
            if ({halted, trap} === {tbl[i].hlt, tbl[i].trp} && icount === 16'(ic0 + tbl[i].inc)) n_pass++;
            else $display("FAIL after_op%0d(%h): got halted=%b trap=%b icount=%0d, want halted=%b trap=%b icount=%0d",
                          i, tbl[i].op, halted, trap, icount, tbl[i].hlt, tbl[i].trp, ic0 + tbl[i].inc);
            if (tbl[i].hlt) begin
                @(negedge CLK);
                do_reset();
            end
        end
        build_plan(4'h0, 1'b0, 5);
        run_plan(4'h0, 1'b0, 1'b0);
        build_plan(4'h1, 1'b0, 0);
        run_plan(4'h1, 1'b0, 1'b0);
        run = 1'b1;
        chk(ev("FETCH", 4'h1, 1'b0), "abort_fetch");
        opcode = 4'h1;
        chk(ev("DECODE", 4'h1, 1'b0), "abort_decode");
        reset_n = 1'b0;
        m_ic = 0;
        chk(ev("INIT", 4'h1, 1'b0), "abort_in_odpp");
        chk(ev("INIT", 4'h1, 1'b0), "abort_hold");
        reset_n = 1'b1;
        chk(ev("INIT", 4'h1, 1'b0), "abort_release");
        for (int k = 0; k < 300; k++) begin
            rop = 4'($urandom);
            rz  = 1'($urandom);
            rv  = $urandom_range(0, 3) == 0;
            build_plan(rop, rv, $urandom_range(0, 2));
            run_plan(rop, rz, rv);
            if (plan_term) do_reset();
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
